alu_operand_sequencer: RTL

- Front-end stage that feeds the lab ALU (n-bit operands, 4-bit opcode, 1-bit flag-in) and captures its combinational result.
- An operator loads A, B, then opcode plus flag-in from board inputs, each with one press of a load button.
- The block then drives the ALU for one execute cycle and latches the result and flags for display.
- It sits between the board switch/button I/O and the ALU; its registered outputs drive the ALU inputs directly.

---
 rtl/alu_operand_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer in front of the lab ALU: synchronizes the load/clear buttons, steps A -> B -> opcode -> execute,
// and captures the ALU result for display. Define ALU_SEQ_ACCUMULATE_EN to feed the previous result back into A from DONE.
module alu_operand_sequencer #(
    parameter int n           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] data_in,
    input  logic [3:0]   op_in,
    input  logic         flag_in,
    input  logic         load_btn,
    input  logic         clear_btn,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    output logic         alu_flag_in,
    input  logic [n-1:0] alu_result,
    input  logic [1:0]   alu_flags,
    output logic [n-1:0] result_q,
    output logic [1:0]   flags_q,
    output logic         op_invalid,
    output logic         result_valid,
    output logic [2:0]   state_o
);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state, state_d;

    logic [SYNC_STAGES-1:0] load_sync, clear_sync;
    logic                   load_prev, clear_prev;
    logic                   load_pulse, clear_pulse;

    logic [n-1:0] alu_a_d, alu_b_d, result_d;
    logic [3:0]   alu_ctrl_d;
    logic         alu_flag_in_d, op_invalid_d, result_valid_d;
    logic [1:0]   flags_d;
    logic         is_shift;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values, like real hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_sync  <= '0;
            clear_sync <= '0;
            load_prev  <= 1'b0;
            clear_prev <= 1'b0;
        end else begin
            load_sync  <= {load_sync[SYNC_STAGES-2:0], load_btn};
            clear_sync <= {clear_sync[SYNC_STAGES-2:0], clear_btn};
            load_prev  <= load_sync[SYNC_STAGES-1];
            clear_prev <= clear_sync[SYNC_STAGES-1];
        end
    end

    // One pulse per press, however long the button is held.
    assign load_pulse  = load_sync[SYNC_STAGES-1] & ~load_prev;
    assign clear_pulse = clear_sync[SYNC_STAGES-1] & ~clear_prev;

    // Only the shift opcodes produce a meaningful carry out.
    assign is_shift = (alu_ctrl == 4'd8) || (alu_ctrl == 4'd9);

    // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state;
        alu_a_d        = alu_a;
        alu_b_d        = alu_b;
        alu_ctrl_d     = alu_ctrl;
        alu_flag_in_d  = alu_flag_in;
        result_d       = result_q;
        flags_d        = flags_q;
        op_invalid_d   = op_invalid;
        result_valid_d = result_valid;

        if (clear_pulse) begin
            state_d        = LOAD_A;
            alu_a_d        = '0;
            alu_b_d        = '0;
            alu_ctrl_d     = '0;
            alu_flag_in_d  = 1'b0;
            result_d       = '0;
            flags_d        = '0;
            op_invalid_d   = 1'b0;
            result_valid_d = 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (load_pulse) begin
                        alu_a_d        = data_in;
                        result_valid_d = 1'b0;
                        state_d        = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (load_pulse) begin
                        alu_b_d = data_in;
                        state_d = LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (load_pulse) begin
                        alu_ctrl_d    = op_in;
                        alu_flag_in_d = flag_in;
                        state_d       = EXEC;
                    end
                end
                EXEC: begin
                    result_d       = alu_result;
                    flags_d        = {alu_flags[1], is_shift & alu_flags[0]};
                    op_invalid_d   = (alu_ctrl > 4'd9);
                    result_valid_d = 1'b1;
                    state_d        = DONE;
                end
                DONE: begin
                    if (load_pulse) begin
`ifdef ALU_SEQ_ACCUMULATE_EN
                        alu_a_d = op_invalid ? '0 : result_q;
`else
                        alu_a_d = data_in;
`endif
                        result_valid_d = 1'b0;
                        state_d        = LOAD_B;
                    end
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    // NOTE: this block holds only a handful of control/data flops, so all of them take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD_A;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_ctrl     <= '0;
            alu_flag_in  <= 1'b0;
            result_q     <= '0;
            flags_q      <= '0;
            op_invalid   <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_d;
            alu_a        <= alu_a_d;
            alu_b        <= alu_b_d;
            alu_ctrl     <= alu_ctrl_d;
            alu_flag_in  <= alu_flag_in_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            op_invalid   <= op_invalid_d;
            result_valid <= result_valid_d;
        end
    end

    assign state_o = state;

endmodule
